// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the
// central stall/flush/forwarding controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UseRs;
  logic        ID_UseRt;
  logic [4:0]  EX_Rs;
  logic [4:0]  EX_Rt;
  logic        EX_UseRs;
  logic        EX_UseRt;
  logic [4:0]  EX_RtRd;
  logic [4:0]  MEM_RtRd;
  logic [4:0]  WB_RtRd;
  logic        EX_RegWrite;
  logic        MEM_RegWrite;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic        WB_RegWrite;
  logic        EX_ALUBusy;
  logic        IMem_Ready;
  logic        DMem_Ready;
  logic        MEM_Exception;
  logic [31:0] MEM_RestartPC;
  logic        MEM_IsBDS;
  logic        IF_Stall;
  logic        ID_Stall;
  logic        EX_Stall;
  logic        MEM_Stall;
  logic        WB_Stall;
  logic        IF_Flush;
  logic        ID_Flush;
  logic        EX_Flush;
  logic        MEM_Flush;
  logic [1:0]  FwdA_ID;
  logic [1:0]  FwdB_ID;
  logic [1:0]  FwdA_EX;
  logic [1:0]  FwdB_EX;
  logic        Exc_Redirect;
  logic [31:0] Exc_EPC;
  logic        Exc_IsBDS;
  logic        Exc_Cause;
  logic [31:0] Stall_Cycles;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
    output EX_Rs, EX_Rt, EX_UseRs, EX_UseRt,
    output EX_RtRd, MEM_RtRd, WB_RtRd,
    output EX_RegWrite, MEM_RegWrite,
    output MEM_MemRead, MEM_MemWrite, WB_RegWrite,
    output EX_ALUBusy, IMem_Ready, DMem_Ready,
    output MEM_Exception, MEM_RestartPC, MEM_IsBDS,
    input  IF_Stall, ID_Stall, EX_Stall,
    input  MEM_Stall, WB_Stall,
    input  IF_Flush, ID_Flush, EX_Flush, MEM_Flush,
    input  FwdA_ID, FwdB_ID, FwdA_EX, FwdB_EX,
    input  Exc_Redirect, Exc_EPC, Exc_IsBDS,
    input  Exc_Cause, Stall_Cycles
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
    input  EX_Rs, EX_Rt, EX_UseRs, EX_UseRt,
    input  EX_RtRd, MEM_RtRd, WB_RtRd,
    input  EX_RegWrite, MEM_RegWrite,
    input  MEM_MemRead, MEM_MemWrite, WB_RegWrite,
    input  EX_ALUBusy, IMem_Ready, DMem_Ready,
    input  MEM_Exception, MEM_RestartPC, MEM_IsBDS,
    output IF_Stall, ID_Stall, EX_Stall,
    output MEM_Stall, WB_Stall,
    output IF_Flush, ID_Flush, EX_Flush, MEM_Flush,
    output FwdA_ID, FwdB_ID, FwdA_EX, FwdB_EX,
    output Exc_Redirect, Exc_EPC, Exc_IsBDS,
    output Exc_Cause, Stall_Cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage stall/flush/forwarding control for the 5-stage core,
// including data-memory wait timeout and precise exception entry.
module pipeline_hazard_ctrl #(
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(DMEM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      epc_q, epc_d;
  logic             bds_q, bds_d;
  logic             cause_q, cause_d;
  logic [31:0]      sc_q, sc_d;

  logic       pend, abort, take;
  logic       mem_st, ex_st, id_st, if_st;
  logic       lu, id_dep;
  logic       st_if, st_id, st_ex, st_mem;
  logic       fl_if, fl_id, fl_ex, fl_mem;
  logic       redir;
  logic [1:0] fa_id, fb_id, fa_ex, fb_ex;

  function automatic logic hit(
    input logic [4:0] r,
    input logic [4:0] w,
    input logic       we
  );
    return we && (r == w) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd(
    input logic [4:0] r,
    input logic [4:0] m_rd,
    input logic       m_we,
    input logic       m_ld,
    input logic [4:0] w_rd,
    input logic       w_we
  );
    if (hit(r, m_rd, m_we) && !m_ld)
      return 2'b01;
    else if (hit(r, w_rd, w_we))
      return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    fa_ex = fwd(bus.EX_Rs, bus.MEM_RtRd, bus.MEM_RegWrite,
                bus.MEM_MemRead, bus.WB_RtRd, bus.WB_RegWrite);
    fb_ex = fwd(bus.EX_Rt, bus.MEM_RtRd, bus.MEM_RegWrite,
                bus.MEM_MemRead, bus.WB_RtRd, bus.WB_RegWrite);
    fa_id = fwd(bus.ID_Rs, bus.MEM_RtRd, bus.MEM_RegWrite,
                bus.MEM_MemRead, bus.WB_RtRd, bus.WB_RegWrite);
    fb_id = fwd(bus.ID_Rt, bus.MEM_RtRd, bus.MEM_RegWrite,
                bus.MEM_MemRead, bus.WB_RtRd, bus.WB_RegWrite);
  end

  always_comb begin
    pend  = bus.MEM_MemRead | bus.MEM_MemWrite;
    abort = (state_q == S_WAIT) && (cnt_q == TO_LAST) &&
            !bus.DMem_Ready;
    mem_st = pend & ~bus.DMem_Ready & ~abort;
    lu = bus.MEM_MemRead & (
           (bus.EX_UseRs &
            hit(bus.EX_Rs, bus.MEM_RtRd, bus.MEM_RegWrite)) |
           (bus.EX_UseRt &
            hit(bus.EX_Rt, bus.MEM_RtRd, bus.MEM_RegWrite)));
    ex_st = mem_st | bus.EX_ALUBusy | lu;
    id_dep =
      (bus.ID_UseRs & (
         hit(bus.ID_Rs, bus.EX_RtRd, bus.EX_RegWrite) |
         (bus.MEM_MemRead &
          hit(bus.ID_Rs, bus.MEM_RtRd, bus.MEM_RegWrite)))) |
      (bus.ID_UseRt & (
         hit(bus.ID_Rt, bus.EX_RtRd, bus.EX_RegWrite) |
         (bus.MEM_MemRead &
          hit(bus.ID_Rt, bus.MEM_RtRd, bus.MEM_RegWrite))));
    id_st = ex_st | id_dep;
    if_st = id_st | ~bus.IMem_Ready;
    take  = abort | (bus.MEM_Exception & ~mem_st);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    bds_d   = bds_q;
    cause_d = cause_q;
    st_if   = 1'b0;
    st_id   = 1'b0;
    st_ex   = 1'b0;
    st_mem  = 1'b0;
    fl_if   = 1'b0;
    fl_id   = 1'b0;
    fl_ex   = 1'b0;
    fl_mem  = 1'b0;
    redir   = 1'b0;
    unique case (state_q)
      S_RUN, S_WAIT: begin
        if (take) begin
          // Kill the faulting instruction and everything younger.
          fl_if   = 1'b1;
          fl_id   = 1'b1;
          fl_ex   = 1'b1;
          fl_mem  = 1'b1;
          epc_d   = bus.MEM_RestartPC;
          bds_d   = bus.MEM_IsBDS;
          cause_d = abort;
          cnt_d   = '0;
          state_d = S_REDIR;
        end else begin
          st_if  = if_st;
          st_id  = id_st;
          st_ex  = ex_st;
          st_mem = mem_st;
          if (state_q == S_RUN) begin
            if (mem_st) begin
              state_d = S_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end else if (bus.DMem_Ready) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REDIR: begin
        redir   = 1'b1;
        fl_if   = 1'b1;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
    endcase
    sc_d = sc_q;
    if (st_if && (sc_q != 32'hFFFF_FFFF))
      sc_d = sc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      epc_q   <= '0;
      bds_q   <= 1'b0;
      cause_q <= 1'b0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      bds_q   <= bds_d;
      cause_q <= cause_d;
      sc_q    <= sc_d;
    end
  end

  assign bus.IF_Stall     = rst & st_if;
  assign bus.ID_Stall     = rst & st_id;
  assign bus.EX_Stall     = rst & st_ex;
  assign bus.MEM_Stall    = rst & st_mem;
  assign bus.WB_Stall     = 1'b0;
  assign bus.IF_Flush     = rst & fl_if;
  assign bus.ID_Flush     = rst & fl_id;
  assign bus.EX_Flush     = rst & fl_ex;
  assign bus.MEM_Flush    = rst & fl_mem;
  assign bus.Exc_Redirect = rst & redir;
  assign bus.FwdA_ID      = rst ? fa_id : 2'b00;
  assign bus.FwdB_ID      = rst ? fb_id : 2'b00;
  assign bus.FwdA_EX      = rst ? fa_ex : 2'b00;
  assign bus.FwdB_EX      = rst ? fb_ex : 2'b00;
  assign bus.Exc_EPC      = epc_q;
  assign bus.Exc_IsBDS    = bds_q;
  assign bus.Exc_Cause    = cause_q;
  assign bus.Stall_Cycles = sc_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central producer of the per-stage stall, flush and forwarding controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers of the 5-stage MIPS core.
- Detects load-use and ID-branch hazards and waits on the data-memory handshake, with a timeout.
- Sequences precise exception entry: kill the faulting instruction and all younger ones, latch the EPC, redirect fetch.

Parameters:
DMEM_TIMEOUT, 255, cycles a data access may wait before a bus error is raised (range 2..255).
CNT_W, 8, width of the wait counter.

Ports:
clk in 1 clock
rst in 1 asynchronous active-low reset
ID_Rs/ID_Rt in 5 each; ID_UseRs/ID_UseRt in 1 each: operand consumed in ID (branch compare, jr)
EX_Rs/EX_Rt in 5 each; EX_UseRs/EX_UseRt in 1 each: operand consumed by the ALU
EX_RtRd, MEM_RtRd, WB_RtRd in 5 each: destination registers
EX_RegWrite, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, WB_RegWrite in 1 each
EX_ALUBusy in 1: multicycle unit is busy
IMem_Ready, DMem_Ready in 1 each: memory handshake
MEM_Exception in 1; MEM_RestartPC in 32; MEM_IsBDS in 1
IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall out 1 each
IF_Flush, ID_Flush, EX_Flush, MEM_Flush out 1 each
FwdA_ID, FwdB_ID, FwdA_EX, FwdB_EX out 2 each: 00 register file, 01 MEM ALU result, 10 WB data
Exc_Redirect out 1; Exc_EPC out 32; Exc_IsBDS out 1; Exc_Cause out 1 (0 external, 1 bus timeout)
Stall_Cycles out 32

Behaviour:
- Reset (rst=0, asynchronous) puts the FSM in RUN and clears the counter and all registered outputs: Exc_EPC=0, Exc_IsBDS=0, Exc_Cause=0, Stall_Cycles=0.
- During reset, all combinational outputs are 0.
- A register match requires equal indices, index≠0, and the writer's RegWrite=1. Register $0 is never forwarded and never causes a stall.

Forwarding (combinational):
- EX operand: MEM match with MEM_MemRead=0 gives 01. Otherwise a WB match gives 10. Otherwise 00. MEM has priority over WB.
- ID operand: the same rule, using ID_Rs/ID_Rt.

Stalls (combinational, RUN/DMEM_WAIT only):
- WB_Stall = 0.
- MEM_Stall = (MEM_MemRead|MEM_MemWrite) & ~DMem_Ready & ~timeout_abort.
- EX_Stall = MEM_Stall | EX_ALUBusy | load-use. Load-use = EX_UseRs/Rt matching a MEM load destination (MEM_MemRead=1).
- ID_Stall = EX_Stall | ID_Use operand matching EX_RtRd | ID_Use operand matching a MEM load destination.
- IF_Stall = ID_Stall | ~IMem_Ready.
- Stalls are monotone: an older-stage stall implies every younger-stage stall.

FSM (states RUN, DMEM_WAIT, EXC_REDIRECT):
- RUN, memory access pending and DMem_Ready=0: go to DMEM_WAIT, counter=1.
- DMEM_WAIT: counter increments while DMem_Ready=0. DMem_Ready=1 returns to RUN and clears the counter.
- Timeout: in DMEM_WAIT with counter==DMEM_TIMEOUT-1 and DMem_Ready=0, assert timeout_abort for that cycle. This forces MEM_Stall=0, takes the exception path with cause 1, and goes to EXC_REDIRECT.
- Exception take: in RUN or DMEM_WAIT when (MEM_Exception & ~MEM_Stall) or timeout_abort.
  - Same cycle: IF/ID/EX/MEM_Flush=1 and all stalls forced to 0. This kills the faulting instruction and all younger ones.
  - Clock edge: Exc_EPC←MEM_RestartPC, Exc_IsBDS←MEM_IsBDS, Exc_Cause←timeout_abort. Go to EXC_REDIRECT.
  - MEM_Exception together with timeout_abort: Exc_Cause=1.
- EXC_REDIRECT lasts exactly one cycle: Exc_Redirect=1, IF_Flush=1, other flushes 0, stalls 0. MEM_Exception is ignored. Always returns to RUN.
- MEM_Exception while MEM_Stall=1 is deferred until the access completes.
- Flush outputs are 0 in RUN and DMEM_WAIT except in the exception-take cycle.
- Stall_Cycles increments on every clock with IF_Stall=1 and saturates at 0xFFFFFFFF.
- Reset asserted mid-wait or in EXC_REDIRECT aborts immediately to RUN.

Test Plan:
- Load-use: MEM: lw to $5 (MEM_MemRead=1, MEM_RtRd=5); EX_Rs=5, EX_UseRs=1 -> EX_Stall=ID_Stall=IF_Stall=1, MEM_Stall=0. Next cycle with the load in WB -> FwdA_EX=10, no stall.
- Forward priority: MEM_RtRd=WB_RtRd=7, both RegWrite=1, MEM_MemRead=0, EX_Rt=7 -> FwdB_EX=01. Repeat with index 0 -> 00.
- Branch in ID: ID_Rs=3, ID_UseRs=1, EX_RtRd=3, EX_RegWrite=1 -> ID_Stall=1, EX_Stall=0. Next cycle with the writer in MEM -> FwdA_ID=01.
- DMem wait: sw in MEM, DMem_Ready low 4 cycles -> MEM_Stall=1 for 4 cycles, Stall_Cycles +4, then RUN.
- Timeout with DMEM_TIMEOUT=8, DMem_Ready held low, MEM_RestartPC=0x00400020:
  - Cycle 8 of the access: all flushes=1.
  - Next cycle: Exc_Redirect=1, Exc_EPC=0x00400020, Exc_Cause=1.
- Exception: MEM_Exception=1, MEM_IsBDS=1, MEM_RestartPC=0x80000010 -> same cycle all flushes=1. Next cycle Exc_Redirect=1, Exc_IsBDS=1, Exc_Cause=0. Following cycle RUN, Exc_Redirect=0. Reset pulse during the DMEM_WAIT of the previous scenario -> all outputs 0 immediately.
